pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising clk edge.
REQ-004 SHALL have port pc_sel, input, 2, next-PC selector (00 branch/JAL target, 01 JALR target, 10 PC+4, 11 halt).
REQ-005 SHALL have port branch_target, input, 32, PC-relative target for branch and JAL.
REQ-006 SHALL have port jalr_target, input, 32, register-relative target for JALR.
REQ-007 SHALL have port stall, input, 1, hazard hold: keep PC and outstanding request unchanged.
REQ-008 SHALL have port imem_req, output, 1, instruction fetch request valid.
REQ-009 SHALL have port imem_addr, output, 32, fetch address, equal to pc.
REQ-010 SHALL have port imem_ready, input, 1, memory accepts the request on a cycle where imem_req and imem_ready are both high.
REQ-011 SHALL have port pc, output, 32, current fetch PC.
REQ-012 SHALL have port flush, output, 1, one-cycle pulse that kills IF/ID and ID/EX contents on a redirect.
REQ-013 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-014 SHALL implement an FSM with states RUN, WAIT and HALT.
REQ-015 In RUN, imem_req SHALL be 1; if imem_ready=1 and there is no stall or redirect, pc SHALL advance to pc+4 on the next cycle.
REQ-016 In RUN with imem_ready=0, the FSM SHALL enter WAIT, holding pc and imem_req=1 until the cycle where imem_ready=1.
REQ-017 A redirect (pc_sel=00 or 01) SHALL load pc with branch_target or {jalr_target[31:1],1'b0} next cycle and assert flush for exactly that one cycle, in any state except HALT.
REQ-018 A redirect arriving in WAIT SHALL abandon the outstanding address, take effect next cycle, and return to RUN.
REQ-019 Redirect SHALL take priority over stall; stall SHALL take priority over sequential PC+4.
REQ-020 While stall=1 with no redirect, pc SHALL hold, imem_req SHALL stay 1, and state SHALL be unchanged.
REQ-021 pc_sel=11 SHALL move the FSM to HALT next cycle, with pc holding the current value and no flush.
REQ-022 In HALT, imem_req SHALL be 0, halted SHALL be 1, and all inputs except rst SHALL be ignored; only reset exits HALT.
REQ-023 PC arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0 with no error.
REQ-024 A target with bit 1 set (misaligned) SHALL be loaded unchanged; trapping is out of scope.
REQ-025 flush SHALL be registered and SHALL never be high for two consecutive cycles from a single redirect.

Reset
REQ-026 On rst=1 at a clock edge, outputs SHALL be: pc=RESET_PC, state=RUN, flush=0, halted=0; imem_req SHALL be 1 from the first cycle after reset deasserts.
REQ-027 Reset SHALL override every input, including reset mid-WAIT, mid-flush and in HALT.

Structure
REQ-028 The pc_sel encodings (PC_SEL_BRANCH, PC_SEL_JALR, PC_SEL_SEQ, PC_SEL_HALT) and the FSM state encodings SHALL live in the shared defines/package, alongside the existing opcode and branch defines.
REQ-029 The next-PC selection SHALL be a sub-module, pc_next_mux, that is combinational from pc_sel, pc and the two targets; the FSM and registers SHALL remain in pc_fetch_unit.

Verification
REQ-030 Reset then imem_ready=1 and pc_sel=10 for 4 cycles -> pc = 0, 4, 8, 12; flush=0.
REQ-031 At pc=8, pc_sel=00, branch_target=0x40 -> next pc=0x40, flush high for 1 cycle only.
REQ-032 pc_sel=01, jalr_target=0x103 -> pc=0x102, flush pulse.
REQ-033 imem_ready=0 for 3 cycles at pc=0x10 -> pc stays 0x10 and imem_req=1 throughout; redirect to 0x80 during the 2nd cycle -> pc=0x80 next cycle, state RUN.
REQ-034 stall=1 with pc_sel=00, target 0x20 -> redirect wins; stall=1 with pc_sel=10 -> pc held.
REQ-035 pc_sel=11 at pc=0x24 -> halted=1, imem_req=0, pc=0x24 held for 10 cycles despite redirects; then rst -> pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC selector, fetch FSM states
// and the selected-next-PC bundle passed from the mux to the fetch unit.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEL_BRANCH = 2'b00,
    PC_SEL_JALR   = 2'b01,
    PC_SEL_SEQ    = 2'b10,
    PC_SEL_HALT   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        redirect;
  } next_pc_t;

endpackage

// File: rtl/pc_fetch_unit_next_mux.sv
// Combinational next-PC selection; flags redirects so the fetch FSM can flush.
module pc_next_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [1:0]  pc_sel,
  input  logic [31:0] pc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output next_pc_t    nxt
);

  always_comb begin
    nxt.pc       = pc;
    nxt.redirect = 1'b0;
    unique case (pc_sel_e'(pc_sel))
      PC_SEL_BRANCH: begin
        nxt.pc       = branch_target;
        nxt.redirect = 1'b1;
      end
      PC_SEL_JALR: begin
        // JALR clears bit 0 only; bit 1 misalignment is passed through untouched.
        nxt.pc       = jalr_target & ~32'd1;
        nxt.redirect = 1'b1;
      end
      PC_SEL_SEQ: nxt.pc = pc + 32'd4;
      default:    nxt.pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and RUN/WAIT/HALT request FSM. Priority per cycle:
// redirect > stall > halt > sequential advance (gated by imem_ready).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        flush,
  output logic        halted
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_q, pc_nxt;
  logic         flush_q, flush_nxt;
  next_pc_t     mux;

  pc_next_mux u_next_mux (
    .pc_sel        (pc_sel),
    .pc            (pc_q),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .nxt           (mux)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      flush_q <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    flush_nxt = 1'b0;
    unique case (state)
      ST_HALT: ;
      default: begin
        // A redirect abandons any outstanding request, so it is taken even from WAIT.
        if (mux.redirect) begin
          pc_nxt    = mux.pc;
          flush_nxt = 1'b1;
          state_nxt = ST_RUN;
        end else if (stall) begin
          state_nxt = state;
        end else if (pc_sel == PC_SEL_HALT) begin
          state_nxt = ST_HALT;
        end else if (imem_ready) begin
          pc_nxt    = mux.pc;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
    endcase
  end

  assign imem_req  = (state != ST_HALT);
  assign halted    = (state == ST_HALT);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random traffic
// checked against a cycle-level behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [1:0] S_BR = 2'b00, S_JR = 2'b01, S_SQ = 2'b10, S_HT = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_sel = S_SQ;
  logic [31:0] branch_target = '0, jalr_target = '0;
  logic        stall = 1'b0, imem_ready = 1'b1;
  logic        imem_req, flush, halted;
  logic [31:0] imem_addr, pc;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .flush         (flush),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        halted;
    logic        req;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int compared = 0, mismatched = 0;

  // Reference model: architectural PC and halted flag only.
  logic [31:0] m_pc = RST_PC;
  logic        m_halted = 1'b0;

  task automatic step(input string tag, input logic r, input logic [1:0] s,
                      input logic [31:0] bt, input logic [31:0] jt,
                      input logic st, input logic rdy);
    exp_t e;
    logic f;
    @(negedge clk);
    rst = r; pc_sel = s; branch_target = bt; jalr_target = jt;
    stall = st; imem_ready = rdy;
    f = 1'b0;
    if (r) begin
      m_pc = RST_PC; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (s == S_BR) begin
        m_pc = bt; f = 1'b1;
      end else if (s == S_JR) begin
        m_pc = {jt[31:1], 1'b0}; f = 1'b1;
      end else if (st) begin
        // hold
      end else if (s == S_HT) begin
        m_halted = 1'b1;
      end else if (rdy) begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.flush = f; e.halted = m_halted; e.req = !m_halted; e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: every cycle after the edge, pop one expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (pc !== e.pc || imem_addr !== e.pc || flush !== e.flush ||
            halted !== e.halted || imem_req !== e.req) begin
          mismatched++;
          $display("FAIL %s: got pc=%h addr=%h flush=%b halted=%b req=%b, want pc=%h flush=%b halted=%b req=%b",
                   e.tag, pc, imem_addr, flush, halted, imem_req, e.pc, e.flush, e.halted, e.req);
        end
      end
    end
  end

  initial begin
    logic [1:0]  s;
    logic        r, st, rdy;
    int          roll;
    // Reset then sequential fetch
    step("reset",   1, S_SQ, 0, 0, 0, 1);
    step("seq4",    0, S_SQ, 0, 0, 0, 1);
    step("seq8",    0, S_SQ, 0, 0, 0, 1);
    step("seq12",   0, S_SQ, 0, 0, 0, 1);
    step("reset2",  1, S_SQ, 0, 0, 0, 1);
    step("seq4b",   0, S_SQ, 0, 0, 0, 1);
    step("seq8b",   0, S_SQ, 0, 0, 0, 1);
    step("branch",  0, S_BR, 32'h40, 0, 0, 1);
    step("postbr",  0, S_SQ, 0, 0, 0, 1);
    step("jalr",    0, S_JR, 0, 32'h103, 0, 1);
    step("postjr",  0, S_SQ, 0, 0, 0, 1);
    // Memory wait with redirect in the middle
    step("to10",    0, S_BR, 32'h10, 0, 0, 1);
    step("wait1",   0, S_SQ, 0, 0, 0, 0);
    step("waitbr",  0, S_BR, 32'h80, 0, 0, 0);
    step("wait3",   0, S_SQ, 0, 0, 0, 0);
    step("waitgo",  0, S_SQ, 0, 0, 0, 1);
    // Stall priority
    step("stallbr", 0, S_BR, 32'h20, 0, 1, 1);
    step("stallsq", 0, S_SQ, 0, 0, 1, 1);
    step("stallsq2",0, S_SQ, 0, 0, 1, 0);
    // Halt holds against everything but reset
    step("to24",    0, S_BR, 32'h24, 0, 0, 1);
    step("halt",    0, S_HT, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      step("halthold", 0, 2'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom()), 1);
    step("haltrst", 1, S_SQ, 0, 0, 0, 1);
    // Wraparound and misaligned targets
    step("towrap",  0, S_BR, 32'hFFFF_FFFC, 0, 0, 1);
    step("wrap",    0, S_SQ, 0, 0, 0, 1);
    step("misal",   0, S_BR, 32'h42, 0, 0, 1);
    step("misalsq", 0, S_SQ, 0, 0, 0, 1);
    step("b2b_a",   0, S_JR, 0, 32'h203, 0, 0);
    step("b2b_b",   0, S_BR, 32'h300, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      roll = $urandom_range(0, 99);
      s = (roll < 60) ? S_SQ : (roll < 74) ? S_BR : (roll < 88) ? S_JR :
          (roll < 91) ? S_HT : S_SQ;
      r = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      st = (s != S_HT) && ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      step("rand", r, s, $urandom(), $urandom(), st, rdy);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
